// File: rtl/gpu_pkg.sv
// Shared encodings for the compute core: scheduler (core) states, LSU
// progress states, fetcher states and the LSU operation type.
// No ports; imported by the scheduler, fetcher and lsu.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_DONE     = 3'b010
  } fetcher_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } lsu_op_e;

endpackage

// File: rtl/lsu.sv
// Per-thread load-store unit. Issues one memory read (LDR) or write (STR)
// per instruction over a valid/ready channel and reports progress on
// lsu_state for the scheduler to poll.
//
// Ports:
//   clk, reset (async, active low)
//   enable, core_state, decoded_mem_read_enable, decoded_mem_write_enable,
//   rs (address), rt (store data)                      - from core/decode
//   mem_read_valid/address, mem_read_ready/data        - read channel
//   mem_write_valid/address/data, mem_write_ready      - write channel
//   lsu_state (progress), lsu_out (last loaded value)  - to core
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for an enabled LDR/STR in the REQUEST cycle
// REQUESTING | one cycle: raise valid with the latched address/data
// WAITING    | hold request until the matching ready is seen
// DONE       | operation complete, waiting for core UPDATE
module lsu
  import gpu_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  lsu_state_e           state_q, state_d;
  lsu_op_e              op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic                 rd_valid_q, rd_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;

  logic [ADDR_BITS-1:0] rs_addr;
  logic                 start;
  logic                 ready_seen;

  // Address is the low ADDR_BITS of rs, zero-extended when wider.
  if (ADDR_BITS > DATA_BITS) begin : g_addr_ext
    assign rs_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
  end else begin : g_addr_trunc
    assign rs_addr = rs[ADDR_BITS-1:0];
  end

  assign start = enable && (core_state == CORE_REQUEST) &&
                 (decoded_mem_read_enable || decoded_mem_write_enable);

  // Only the channel matching the latched op can complete it.
  assign ready_seen = (op_q == OP_READ) ? mem_read_ready : mem_write_ready;

  // State register and all datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LSU_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      lsu_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      lsu_out_q  <= lsu_out_d;
    end
  end

  // Next-state logic, plus capture of the operation in the REQUEST cycle
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          state_d = LSU_REQUESTING;
          addr_d  = rs_addr;
          // Read has priority when both decode enables are set.
          if (decoded_mem_read_enable) begin
            op_d = OP_READ;
          end else begin
            op_d   = OP_WRITE;
            data_d = rt;
          end
        end
      end
      LSU_REQUESTING: state_d = LSU_WAITING;
      LSU_WAITING:    if (ready_seen) state_d = LSU_DONE;
      LSU_DONE:       if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
      default:        state_d = LSU_IDLE;
    endcase
  end

  // Registered-output next values
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    lsu_out_d  = lsu_out_q;
    case (state_q)
      LSU_REQUESTING: begin
        if (op_q == OP_READ) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = addr_q;
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = data_q;
        end
      end
      LSU_WAITING: begin
        if (op_q == OP_READ && mem_read_ready) begin
          lsu_out_d  = mem_read_data;
          rd_valid_d = 1'b0;
        end else if (op_q == OP_WRITE && mem_write_ready) begin
          wr_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = lsu_out_q;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Per-thread load-store unit inside each compute core. One instance per thread.
- Issues one memory read or write per LDR/STR instruction over a valid/ready handshake to the memory controller.
- Publishes its progress on lsu_state, which the core scheduler polls in WAIT before moving to EXECUTE.
- Sits between the core-wide state/decode signals and one memory-controller channel per thread.

Parameters:
- DATA_BITS, 8, width of register operands, read data and write data.
- ADDR_BITS, 8, memory address width; address is rs[ADDR_BITS-1:0], zero-extended if ADDR_BITS > DATA_BITS.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  thread active in current block; sampled only in IDLE.
- core_state  in  3  scheduler state (REQUEST=3'b011, UPDATE=3'b110).
- decoded_mem_read_enable  in  1  current instruction is LDR.
- decoded_mem_write_enable  in  1  current instruction is STR.
- rs  in  DATA_BITS  address operand.
- rt  in  DATA_BITS  store data operand.
- mem_read_valid  out  1  read request pending.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  read complete; mem_read_data valid this cycle.
- mem_read_data  in  DATA_BITS  returned load data.
- mem_write_valid  out  1  write request pending.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  store data.
- mem_write_ready  in  1  write accepted/complete.
- lsu_state  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- lsu_out  out  DATA_BITS  last loaded value, consumed by register writeback.

Behaviour:
- Reset (reset low, asynchronous): lsu_state=IDLE and every output = 0, including lsu_out. A reset mid-operation drops valid immediately, with no completion.
- All other updates occur on posedge clk. Every output is registered.
- IDLE:
  - Advances only if enable=1 and core_state==REQUEST and (read_en|write_en); otherwise stays IDLE.
  - If read_en=1, goes to REQUESTING as a read and latches the address. If both read_en and write_en are 1, the read wins and the write is ignored.
  - Else if write_en=1, goes to REQUESTING as a write and latches the address and rt.
  - The operation type is held in an internal op register.
- REQUESTING (exactly 1 cycle):
  - Read: mem_read_valid<=1, mem_read_address<=latched address.
  - Write: mem_write_valid<=1, mem_write_address<=latched address, mem_write_data<=latched rt.
  - Then goes to WAITING.
- WAITING:
  - Valid, address and data are held stable until the matching ready is seen high.
  - Read: on mem_read_ready=1, lsu_out<=mem_read_data, mem_read_valid<=0, go to DONE.
  - Write: on mem_write_ready=1, mem_write_valid<=0, go to DONE.
  - The opposite channel's ready is ignored.
  - There is no timeout; WAITING lasts indefinitely.
- DONE:
  - Holds until core_state==UPDATE, then goes to IDLE.
  - lsu_out keeps its value until the next completed load; stores never modify it.
- Minimum latency from REQUEST to DONE: REQUEST cycle -> REQUESTING -> WAITING -> DONE on the cycle after ready. A 0-wait memory completes in 3 clocks.
- ready seen in REQUESTING is ignored; it is only sampled in WAITING.
- enable falling mid-operation does not abort the operation.
- Inputs rs, rt and the decode enables may change after the REQUEST cycle without effect.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state encodings (IDLE..DONE, 3 bits).
  - lsu_state encodings (2 bits).
  - fetcher_state encodings.
- The scheduler and lsu both import gpu_pkg.
- No sub-module; a single FSM with an op register, an address/data latch and an output register.

Test Plan:
- Load, zero-wait: enable=1, read_en=1, rs=8'h2A, core_state=REQUEST. Memory returns ready=1 with data 8'h5C the cycle after valid rises -> address=8'h2A; lsu_state 01->10->11; lsu_out=8'h5C; valid low in DONE; core_state=UPDATE -> IDLE.
- Store with 4-cycle stall: write_en=1, rs=8'h10, rt=8'h77, ready delayed 4 cycles -> mem_write_valid/address/data held at 1/8'h10/8'h77 for all WAITING cycles; DONE after ready; lsu_out unchanged.
- Both enables high: read_en=write_en=1 -> only mem_read_valid asserts; mem_write_valid stays 0.
- Disabled thread: enable=0, read_en=1, core_state=REQUEST -> lsu_state stays 00, no valid asserted.
- Async reset in WAITING: assert reset low between clock edges -> mem_read_valid and lsu_state go to 0 immediately, lsu_out=0.
- Stray ready: mem_read_ready=1 during REQUESTING, then 0 for 2 cycles, then 1 -> DONE only after the second ready; the wrong-channel mem_write_ready pulse during a read is ignored.
